// File: rtl/adc_result_serializer.sv
// Captures SAR conversion results on the rising edge of the selected finished strobe,
// buffers them in a small FIFO and sends each one as a 16-bit framed word, MSB first.
module adc_result_serializer #(
  parameter int DEPTH     = 4,
  parameter int FRAME_GAP = 1
) (
  input  logic                     clk_dig_in,
  input  logic                     rst_n,
  input  logic [9:0]               result_in,
  input  logic                     conv_finished_in,
  input  logic                     conv_finished_osr_in,
  input  logic                     osr_mode_in,
  input  logic                     tx_enable_in,
  output logic                     tx_frame_out,
  output logic                     tx_data_out,
  output logic [$clog2(DEPTH):0]   fifo_level_out,
  output logic                     overflow_out
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2} state_t;

  logic          cf_q, cfo_q;
  logic [3:0]    seq_q;
  logic [14:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  state_t        state_q;
  logic [15:0]   sr_q;
  logic [3:0]    bit_cnt_q;
  logic [2:0]    gap_cnt_q;
  logic          frame_q, data_q;

  logic          event_s, full_s, pop_s, push_s, drop_s;
  logic [14:0]   word_s, head_s;

  // Event detection, FIFO bookkeeping and sticky overflow next-state
  always_comb begin
    event_s = osr_mode_in ? (conv_finished_osr_in & ~cfo_q) : (conv_finished_in & ~cf_q);
    full_s  = (level_q == LW'(DEPTH));
    pop_s   = (state_q == IDLE) && tx_enable_in && (level_q != '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
    push_s  = event_s && (!full_s || pop_s);
    drop_s  = event_s && full_s && !pop_s;
    word_s  = {osr_mode_in, seq_q, result_in};
    head_s  = mem_q[rd_ptr_q];
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (pop_s) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Edge registers, sequence counter and FIFO storage
  always_ff @(posedge clk_dig_in or negedge rst_n) begin
    if (!rst_n) begin
      cf_q     <= 1'b0;
      cfo_q    <= 1'b0;
      seq_q    <= 4'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 15'd0;
    end else begin
      cf_q    <= conv_finished_in;
      cfo_q   <= conv_finished_osr_in;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      if (event_s) seq_q <= seq_q + 4'd1;
      if (push_s) begin
        mem_q[wr_ptr_q] <= word_s;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_s) rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // Transmit FSM; frame and data are registered alongside the state
  always_ff @(posedge clk_dig_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sr_q      <= 16'd0;
      bit_cnt_q <= 4'd0;
      gap_cnt_q <= 3'd0;
      frame_q   <= 1'b0;
      data_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          frame_q <= 1'b0;
          data_q  <= 1'b0;
          if (pop_s) begin
            sr_q      <= {ovf_q, head_s};
            data_q    <= ovf_q;
            frame_q   <= 1'b1;
            bit_cnt_q <= 4'd0;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_cnt_q == 4'd15) begin
            frame_q   <= 1'b0;
            data_q    <= 1'b0;
            gap_cnt_q <= 3'd0;
            state_q   <= GAP;
          end else begin
            bit_cnt_q <= bit_cnt_q + 4'd1;
            data_q    <= sr_q[14];
            sr_q      <= {sr_q[14:0], 1'b0};
          end
        end
        GAP: begin
          frame_q <= 1'b0;
          data_q  <= 1'b0;
          if (gap_cnt_q == 3'(FRAME_GAP - 1)) begin
            state_q <= IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + 3'd1;
          end
        end
        default: begin
          frame_q <= 1'b0;
          data_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx_frame_out   = frame_q;
  assign tx_data_out    = data_q;
  assign fifo_level_out = level_q;
  assign overflow_out   = ovf_q;

endmodule

// File: tb/tb_adc_result_serializer.sv
// Directed bench for adc_result_serializer: expected words queued at stimulus time,
// popped and compared when a complete 16-bit frame has been received.
module tb_adc_result_serializer;

  localparam int DEPTH     = 4;
  localparam int FRAME_GAP = 1;

  logic       clk_dig_in = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] result_in = 10'd0;
  logic       conv_finished_in = 1'b0;
  logic       conv_finished_osr_in = 1'b0;
  logic       osr_mode_in = 1'b0;
  logic       tx_enable_in = 1'b0;
  logic       tx_frame_out, tx_data_out, overflow_out;
  logic [$clog2(DEPTH):0] fifo_level_out;

  int total = 0;
  int bad = 0;
  logic [15:0] exp_q[$];
  logic [3:0]  seq_m = 4'd0;
  int rx_cnt = 0;
  int idle_run = 0;
  int last_gap = 0;
  logic [15:0] rx_word = 16'd0;
  logic [15:0] exp_w;

  adc_result_serializer #(.DEPTH(DEPTH), .FRAME_GAP(FRAME_GAP)) dut (
    .clk_dig_in(clk_dig_in), .rst_n(rst_n), .result_in(result_in),
    .conv_finished_in(conv_finished_in), .conv_finished_osr_in(conv_finished_osr_in),
    .osr_mode_in(osr_mode_in), .tx_enable_in(tx_enable_in),
    .tx_frame_out(tx_frame_out), .tx_data_out(tx_data_out),
    .fifo_level_out(fifo_level_out), .overflow_out(overflow_out)
  );

  always #5 clk_dig_in = ~clk_dig_in;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "run did not finish");
  end

  // Frame receiver: assembles words and compares against the scoreboard
  always @(negedge clk_dig_in) begin
    if (!rst_n) begin
      rx_cnt = 0;
      idle_run = 0;
    end else if (tx_frame_out) begin
      if (rx_cnt == 0) last_gap = idle_run;
      idle_run = 0;
      rx_word = {rx_word[14:0], tx_data_out};
      rx_cnt++;
      if (rx_cnt == 16) begin
        rx_cnt = 0;
        total++;
        assert (exp_q.size() > 0) else begin
          bad++;
          $error("FAIL frame_unexpected got=%h exp=none", rx_word);
        end
        if (exp_q.size() > 0) begin
          exp_w = exp_q.pop_front();
          total++;
          assert (rx_word === exp_w) else begin
            bad++;
            $error("FAIL frame_word got=%h exp=%h", rx_word, exp_w);
          end
        end
      end
    end else begin
      idle_run++;
      total++;
      assert ({rx_cnt == 0, tx_data_out} === 2'b10) else begin
        bad++;
        $error("FAIL idle_line bits_in_frame=%0d data=%b exp bits=0 data=0", rx_cnt, tx_data_out);
      end
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    conv_finished_in = 1'b0;
    conv_finished_osr_in = 1'b0;
    exp_q.delete();
    seq_m = 4'd0;
    repeat (2) @(posedge clk_dig_in);
    #1 rst_n = 1'b1;
  endtask

  // One-cycle pulse on the input selected by osr_mode_in, one low cycle after it
  task automatic pulse(input logic [9:0] res, input logic ovf, input logic keep);
    @(posedge clk_dig_in);
    #1;
    result_in = res;
    if (osr_mode_in) conv_finished_osr_in = 1'b1;
    else conv_finished_in = 1'b1;
    if (keep) exp_q.push_back({ovf, osr_mode_in, seq_m, res});
    seq_m = seq_m + 4'd1;
    @(posedge clk_dig_in);
    #1;
    conv_finished_in = 1'b0;
    conv_finished_osr_in = 1'b0;
    result_in = 10'h2AA;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || tx_frame_out || fifo_level_out != '0) && n < 400) begin
      @(negedge clk_dig_in);
      n++;
    end
    total++;
    assert (n < 400) else begin
      bad++;
      $error("FAIL %s wait_cycles=%0d limit=400 pending=%0d", tag, n, exp_q.size());
    end
  endtask

  initial begin
    #3;
    check("rst_frame", 16'(tx_frame_out), 16'd0);
    check("rst_data", 16'(tx_data_out), 16'd0);
    check("rst_level", 16'(fifo_level_out), 16'd0);
    check("rst_ovf", 16'(overflow_out), 16'd0);
    do_reset();

    // 1: single result, latency and frame content
    tx_enable_in = 1'b1;
    @(posedge clk_dig_in);
    #1;
    result_in = 10'h326;
    conv_finished_in = 1'b1;
    exp_q.push_back({1'b0, 1'b0, seq_m, 10'h326});
    seq_m = seq_m + 4'd1;
    @(negedge clk_dig_in);
    check("t1_level_c0", 16'(fifo_level_out), 16'd0);
    @(posedge clk_dig_in);
    #1 conv_finished_in = 1'b0;
    @(negedge clk_dig_in);
    check("t1_level_c1", 16'(fifo_level_out), 16'd1);
    check("t1_frame_c1", 16'(tx_frame_out), 16'd0);
    @(negedge clk_dig_in);
    check("t1_frame_c2", 16'(tx_frame_out), 16'd1);
    check("t1_msb_c2", 16'(tx_data_out), 16'd0);
    check("t1_level_c2", 16'(fifo_level_out), 16'd0);
    drain("t1_drain");
    check("t1_ovf", 16'(overflow_out), 16'd0);

    // 2: two results five cycles apart, minimum frame spacing
    do_reset();
    pulse(10'h326, 1'b0, 1'b1);
    repeat (3) @(posedge clk_dig_in);
    pulse(10'h3CC, 1'b0, 1'b1);
    drain("t2_drain");
    check("t2_gap", 16'(last_gap), 16'(FRAME_GAP + 1));

    // 3: OSR mode ignores conv_finished_in
    do_reset();
    osr_mode_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_dig_in);
      #1 conv_finished_in = 1'b1;
      @(posedge clk_dig_in);
      #1 conv_finished_in = 1'b0;
    end
    pulse(10'h1B2, 1'b0, 1'b1);
    @(posedge clk_dig_in);
    #1 conv_finished_in = 1'b1;
    @(posedge clk_dig_in);
    #1 conv_finished_in = 1'b0;
    drain("t3_drain");
    check("t3_level", 16'(fifo_level_out), 16'd0);
    osr_mode_in = 1'b0;

    // 4: overflow with transmit held off, then release
    do_reset();
    tx_enable_in = 1'b0;
    pulse(10'd1, 1'b1, 1'b1);
    pulse(10'd2, 1'b0, 1'b1);
    pulse(10'd3, 1'b0, 1'b1);
    pulse(10'd4, 1'b0, 1'b1);
    pulse(10'd5, 1'b0, 1'b0);
    @(negedge clk_dig_in);
    check("t4_level_full", 16'(fifo_level_out), 16'(DEPTH));
    check("t4_ovf_set", 16'(overflow_out), 16'd1);
    @(posedge clk_dig_in);
    #1 tx_enable_in = 1'b1;
    @(negedge clk_dig_in);
    check("t4_ovf_before_load", 16'(overflow_out), 16'd1);
    @(negedge clk_dig_in);
    check("t4_frame_started", 16'(tx_frame_out), 16'd1);
    check("t4_ovf_cleared", 16'(overflow_out), 16'd0);
    check("t4_level_after_pop", 16'(fifo_level_out), 16'(DEPTH - 1));
    drain("t4_drain");
    pulse(10'h0F0, 1'b0, 1'b1);
    drain("t4_seq_after_drop");

    // 5: level held high gives one event only
    do_reset();
    @(posedge clk_dig_in);
    #1;
    result_in = 10'h055;
    conv_finished_in = 1'b1;
    exp_q.push_back({1'b0, 1'b0, seq_m, 10'h055});
    seq_m = seq_m + 4'd1;
    repeat (10) @(posedge clk_dig_in);
    #1 conv_finished_in = 1'b0;
    pulse(10'h0AA, 1'b0, 1'b1);
    drain("t5_drain");

    // 6: reset in the middle of a frame
    do_reset();
    pulse(10'h2F0, 1'b0, 1'b1);
    pulse(10'h133, 1'b0, 1'b1);
    for (int n = 0; n < 100 && !tx_frame_out; n++) @(negedge clk_dig_in);
    check("t6_frame_seen", 16'(tx_frame_out), 16'd1);
    repeat (7) @(negedge clk_dig_in);
    #2 rst_n = 1'b0;
    #1;
    check("t6_frame_drop", 16'(tx_frame_out), 16'd0);
    check("t6_data_drop", 16'(tx_data_out), 16'd0);
    check("t6_level_clear", 16'(fifo_level_out), 16'd0);
    do_reset();
    pulse(10'h111, 1'b0, 1'b1);
    drain("t6_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
